// File: rtl/spi_read_mux.sv
// SPI slave read mux: an ABIT-bit address on mosi selects one of NCH NBIT-bit channels, which is shifted out MSB first on miso.
// Pins reach the FSM through a 2-FF synchroniser plus an edge stage (3 clk pin-to-edge); there is no backpressure, sclk paces everything.
`timescale 1ns/1ps
module spi_read_mux #(
   parameter int NBIT     = 32,
   parameter int ABIT     = 8,
   parameter int NCH      = 4,
   parameter int BASE_ADR = 1,
   parameter bit CPOL     = 1'b0
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  sclk,
   input  logic                  mosi,
   input  logic                  cs,
   input  logic [NCH*NBIT-1:0]   inport,
   output logic                  miso,
   output logic                  miso_oe,
   output logic                  hit,
   output logic [NCH-1:0]        clr,
   output logic                  busy
);

   localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int CMAX = (NBIT > ABIT) ? NBIT : ABIT;
   localparam int CNTW = $clog2(CMAX + 1);

   localparam logic [ABIT:0] ADR_LO = (ABIT+1)'(BASE_ADR);
   localparam logic [ABIT:0] ADR_HI = (ABIT+1)'(BASE_ADR + NCH - 1);

   localparam logic [CNTW-1:0] ADR_LAST  = CNTW'(ABIT - 1);
   localparam logic [CNTW-1:0] DATA_LAST = CNTW'(NBIT - 1);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] ADR  = 3'd1;
   localparam logic [2:0] DATA = 3'd2;
   localparam logic [2:0] SKIP = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   // ------------------------------------------------------------------
   // Synchronisers: [0],[1] are the 2-FF synchroniser, [2] the edge stage
   // ------------------------------------------------------------------
   logic [2:0] sclk_s;
   logic [2:0] cs_s;
   logic [1:0] mosi_s;
   logic [2:0] fill;

   always_ff @(posedge clk) begin
      if (srst) begin
         sclk_s <= {3{CPOL}};
         cs_s   <= 3'b111;
         mosi_s <= 2'b00;
         fill   <= 3'b000;
      end else begin
         sclk_s <= {sclk_s[1:0], sclk};
         cs_s   <= {cs_s[1:0], cs};
         mosi_s <= {mosi_s[0], mosi};
         fill   <= {fill[1:0], 1'b1};
      end
   end

   // Edges are masked until the pipeline holds real pin samples, so a cs
   // already low when reset is released does not look like a falling edge.
   logic live;
   logic sclk_n1, sclk_n2;
   logic smp_edge, shf_edge;
   logic cs_fall, cs_rise;
   logic mosi_bit;

   assign live     = fill[2];
   assign sclk_n1  = sclk_s[1] ^ CPOL;
   assign sclk_n2  = sclk_s[2] ^ CPOL;
   assign smp_edge = live &  sclk_n1 & ~sclk_n2;
   assign shf_edge = live & ~sclk_n1 &  sclk_n2;
   assign cs_fall  = live & ~cs_s[1] &  cs_s[2];
   assign cs_rise  = live &  cs_s[1] & ~cs_s[2];
   assign mosi_bit = mosi_s[1];

   // ------------------------------------------------------------------
   // Address decode on the value the address register will hold after
   // the current sample edge
   // ------------------------------------------------------------------
   logic [2:0]      state;
   logic [CNTW-1:0] cnt;
   logic [ABIT-1:0] adr;
   logic [NBIT-1:0] sreg;
   logic [CW-1:0]   ch;
   logic            seen;

   logic [ABIT-1:0] adr_nxt;
   logic [ABIT:0]   adr_ext;
   logic [ABIT:0]   adr_off;
   logic            adr_match;
   logic [NBIT-1:0] sel_word;
   logic [CW-1:0]   sel_ch;

   assign adr_nxt   = {adr[ABIT-2:0], mosi_bit};
   assign adr_ext   = {1'b0, adr_nxt};
   assign adr_off   = adr_ext - ADR_LO;
   assign adr_match = (adr_ext >= ADR_LO) && (adr_ext <= ADR_HI);

   always_comb begin
      sel_word = '0;
      sel_ch   = '0;
      for (int k = 0; k < NCH; k++) begin
         if (adr_off == (ABIT+1)'(k)) begin
            sel_word = inport[k*NBIT +: NBIT];
            sel_ch   = CW'(k);
         end
      end
   end

   // ------------------------------------------------------------------
   // FSM and shift datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (srst) begin
         state   <= IDLE;
         cnt     <= '0;
         adr     <= '0;
         sreg    <= '0;
         ch      <= '0;
         seen    <= 1'b0;
         miso    <= 1'b0;
         miso_oe <= 1'b0;
         hit     <= 1'b0;
         clr     <= '0;
      end else begin
         hit <= 1'b0;
         clr <= '0;
         if (cs_rise) begin
            state   <= IDLE;
            cnt     <= '0;
            seen    <= 1'b0;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  miso    <= 1'b0;
                  miso_oe <= 1'b0;
                  if (cs_fall) begin
                     state <= ADR;
                     cnt   <= '0;
                     adr   <= '0;
                  end
               end
               ADR: begin
                  if (smp_edge) begin
                     adr <= adr_nxt;
                     cnt <= cnt + 1'b1;
                     if (cnt == ADR_LAST) begin
                        cnt  <= '0;
                        seen <= 1'b0;
                        if (adr_match) begin
                           sreg    <= sel_word;
                           ch      <= sel_ch;
                           miso    <= sel_word[NBIT-1];
                           miso_oe <= 1'b1;
                           hit     <= 1'b1;
                           state   <= DATA;
                        end else begin
                           miso    <= 1'b0;
                           miso_oe <= 1'b0;
                           state   <= SKIP;
                        end
                     end
                  end
               end
               DATA: begin
                  if (smp_edge) begin
                     cnt  <= cnt + 1'b1;
                     seen <= 1'b1;
                     if (cnt == DATA_LAST) begin
                        clr     <= NCH'(1) << ch;
                        miso    <= 1'b0;
                        miso_oe <= 1'b0;
                        state   <= DONE;
                     end
                  end else if (shf_edge && seen) begin
                     // The shift edge right after decode is skipped so the
                     // MSB stays up for the master's first data sample.
                     sreg <= {sreg[NBIT-2:0], 1'b0};
                     miso <= sreg[NBIT-2];
                  end
               end
               SKIP, DONE: begin
                  miso    <= 1'b0;
                  miso_oe <= 1'b0;
               end
               default: begin
                  state   <= IDLE;
                  miso    <= 1'b0;
                  miso_oe <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_read_mux.sv
// Bench for spi_read_mux: a bit-banged SPI master issues directed reads, a monitor rebuilds each transaction and scores it.
`timescale 1ns/1ps
module tb_spi_read_mux;
   localparam int NBIT = 32;
   localparam int ABIT = 8;
   localparam int NCH  = 4;
   localparam int H    = 5;

   logic                clk = 1'b0;
   logic                srst = 1'b1;
   logic                sclk = 1'b0;
   logic                mosi = 1'b0;
   logic                cs = 1'b1;
   logic [NCH*NBIT-1:0] inport = '0;
   logic                miso;
   logic                miso_oe;
   logic                hit;
   logic [NCH-1:0]      clr;
   logic                busy;

   spi_read_mux #(.NBIT(NBIT), .ABIT(ABIT), .NCH(NCH), .BASE_ADR(1), .CPOL(1'b0)) dut (
      .clk(clk), .srst(srst), .sclk(sclk), .mosi(mosi), .cs(cs),
      .inport(inport), .miso(miso), .miso_oe(miso_oe), .hit(hit), .clr(clr), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] word;
      int          nbits;
      int          oe;
      int          hits;
      int          clrs;
      logic [3:0]  clrv;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   bit   in_xfer = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_x(input logic [63:0] word, input int nbits, input int oe,
                           input int hits, input int clrs, input logic [3:0] clrv);
      exp_t e;
      e.word = word; e.nbits = nbits; e.oe = oe; e.hits = hits; e.clrs = clrs; e.clrv = clrv;
      q.push_back(e);
   endtask

   // One read: address phase, ndata data clocks, optional inport change and srst pulse.
   task automatic xfer(input logic [7:0] a, input int ndata, input int chg_bit,
                       input logic [31:0] chg_val, input bit do_srst);
      cs = 1'b0;
      tick(H);
      for (int i = 0; i < ABIT; i++) begin
         mosi = a[ABIT-1-i];
         tick(H);
         sclk = 1'b1;
         tick(H);
         sclk = 1'b0;
      end
      mosi = 1'b0;
      for (int j = 0; j < ndata; j++) begin
         tick(H);
         sclk = 1'b1;
         if (j + 1 == chg_bit) inport[31:0] = chg_val;
         tick(H);
         sclk = 1'b0;
      end
      tick(H);
      if (do_srst) begin
         srst = 1'b1;
         tick(1);
         srst = 1'b0;
         @(negedge clk);
         chk("srst_miso", miso, 0);
         chk("srst_miso_oe", miso_oe, 0);
         chk("srst_hit", hit, 0);
         chk("srst_clr", clr, 0);
         chk("srst_busy", busy, 0);
         tick(8);
         chk("idle_cs_low_busy", busy, 0);
      end
      tick(2);
      cs = 1'b1;
      tick(12);
   endtask

   // Monitor: rebuilds what the master saw on miso at each sclk rise.
   initial begin : monitor
      logic        cs_prev, sclk_prev;
      logic [63:0] word;
      int          nrise, nbits, oe_cnt, hit_cnt, clr_cnt;
      logic [3:0]  clr_or;
      exp_t        e;
      cs_prev = 1'b1; sclk_prev = 1'b0;
      word = '0; nrise = 0; nbits = 0; oe_cnt = 0; hit_cnt = 0; clr_cnt = 0; clr_or = '0;
      forever begin
         @(negedge clk);
         if (!in_xfer) begin
            if (cs_prev && !cs) begin
               in_xfer = 1'b1;
               word = '0; nrise = 0; nbits = 0; oe_cnt = 0;
               hit_cnt = 0; clr_cnt = 0; clr_or = '0;
            end
         end else begin
            if (sclk && !sclk_prev) begin
               nrise++;
               if (nrise > ABIT) begin
                  word = {word[62:0], miso};
                  nbits++;
                  if (miso_oe) oe_cnt++;
               end
            end
            if (hit) hit_cnt++;
            if (clr != '0) begin clr_cnt++; clr_or |= clr; end
            if (cs && !cs_prev) begin
               repeat (4) begin
                  @(negedge clk);
                  if (hit) hit_cnt++;
                  if (clr != '0) begin clr_cnt++; clr_or |= clr; end
               end
               chk("busy_after_cs_rise", busy, 0);
               if (q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_xfer actual=1 required=0");
               end else begin
                  e = q.pop_front();
                  chk("nbits", nbits, e.nbits);
                  chk("word", word, e.word);
                  chk("oe_bits", oe_cnt, e.oe);
                  chk("hit_pulses", hit_cnt, e.hits);
                  chk("clr_pulses", clr_cnt, e.clrs);
                  chk("clr_value", clr_or, e.clrv);
               end
               in_xfer = 1'b0;
            end
         end
         cs_prev = cs;
         sclk_prev = sclk;
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int waited;
      srst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_miso", miso, 0);
      chk("rst_miso_oe", miso_oe, 0);
      chk("rst_hit", hit, 0);
      chk("rst_clr", clr, 0);
      chk("rst_busy", busy, 0);
      tick(1);
      srst = 1'b0;
      tick(6);

      // ch0 full read
      inport[0*32 +: 32] = 32'hDEEDBEEF;
      inport[2*32 +: 32] = 32'h00000044;
      inport[1*32 +: 32] = 32'hA5C30F96;
      inport[3*32 +: 32] = 32'h80000001;
      expect_x(64'hDEEDBEEF, 32, 32, 1, 1, 4'b0001);
      xfer(8'h01, 32, 0, 32'h0, 1'b0);

      // ch2
      expect_x(64'h00000044, 32, 32, 1, 1, 4'b0100);
      xfer(8'h03, 32, 0, 32'h0, 1'b0);

      // one above the top channel
      expect_x(64'h0, 32, 0, 0, 0, 4'b0000);
      xfer(8'h05, 32, 0, 32'h0, 1'b0);

      // one below channel 0
      expect_x(64'h0, 32, 0, 0, 0, 4'b0000);
      xfer(8'h00, 32, 0, 32'h0, 1'b0);

      // top channel
      expect_x(64'h80000001, 32, 32, 1, 1, 4'b1000);
      xfer(8'h04, 32, 0, 32'h0, 1'b0);

      // inport changes mid-word; snapshot must hold
      inport[0*32 +: 32] = 32'h00000045;
      expect_x(64'h00000045, 32, 32, 1, 1, 4'b0001);
      xfer(8'h01, 32, 10, 32'hFFFFFFFF, 1'b0);

      // abort after 16 data bits, then a clean read
      inport[0*32 +: 32] = 32'h12345678;
      expect_x(64'h1234, 16, 16, 1, 0, 4'b0000);
      xfer(8'h01, 16, 0, 32'h0, 1'b0);
      expect_x(64'h12345678, 32, 32, 1, 1, 4'b0001);
      xfer(8'h01, 32, 0, 32'h0, 1'b0);

      // srst after 10 data bits of ch1 (top 10 bits of 0xA5C30F96 = 0x297), then a clean read
      expect_x(64'h297, 10, 10, 1, 0, 4'b0000);
      xfer(8'h02, 10, 0, 32'h0, 1'b1);
      expect_x(64'hA5C30F96, 32, 32, 1, 1, 4'b0010);
      xfer(8'h02, 32, 0, 32'h0, 1'b0);

      waited = 0;
      while ((q.size() != 0 || in_xfer) && waited < 200) begin
         tick(1);
         waited++;
      end
      chk("scoreboard_drained", q.size(), 0);
      chk("monitor_idle", in_xfer, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
